// File: rtl/demux_2_stream.sv
// Routes one valid/ready input stream into one of two independent FIFOs,
// each drained by its own valid/ready consumer, with per-output delivery counters.
module demux_2_stream #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [15:0]      count0,
  output logic [15:0]      count1
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Occupancy is one bit wider than the pointers so that full and empty differ.
  localparam logic [AW:0]   OCC_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem0_q [DEPTH];
  logic [WIDTH-1:0] mem1_q [DEPTH];

  logic [1:0][AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0][AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0][AW:0]   occ_q,    occ_d;
  logic [1:0][15:0]   cnt_q,    cnt_d;

  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;

  always_comb begin
    out_ready = {out1_ready, out0_ready};
    for (int k = 0; k < 2; k++) begin
      full[k]  = (occ_q[k] == OCC_FULL);
      empty[k] = (occ_q[k] == '0);
    end
    // A full FIFO refuses even when it is being popped at the same edge.
    in_ready = in_select ? ~full[1] : ~full[0];
    push[0]  = ~rst & in_valid & in_ready & ~in_select;
    push[1]  = ~rst & in_valid & in_ready &  in_select;
    pop      = out_ready & ~empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    for (int k = 0; k < 2; k++) begin
      if (push[k]) begin
        wr_ptr_d[k] = wr_ptr_q[k] + PTR_ONE;
      end
      if (pop[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + PTR_ONE;
        cnt_d[k]    = cnt_q[k] + 16'd1;
      end
      case ({push[k], pop[k]})
        2'b10:   occ_d[k] = occ_q[k] + OCC_ONE;
        2'b01:   occ_d[k] = occ_q[k] - OCC_ONE;
        default: occ_d[k] = occ_q[k];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage holds data only; its contents are meaningless until pointers cover them.
  always_ff @(posedge clk) begin
    if (push[0]) begin
      mem0_q[wr_ptr_q[0]] <= in_data;
    end
    if (push[1]) begin
      mem1_q[wr_ptr_q[1]] <= in_data;
    end
  end

  always_comb begin
    out0_valid = ~empty[0];
    out1_valid = ~empty[1];
    out0_data  = empty[0] ? '0 : mem0_q[rd_ptr_q[0]];
    out1_data  = empty[1] ? '0 : mem1_q[rd_ptr_q[1]];
    count0     = cnt_q[0];
    count1     = cnt_q[1];
  end

endmodule

// File: tb/tb_demux_2_stream.sv
// Bench for demux_2_stream: queue-based reference model checked every cycle,
// plus directed literal checks of routing, backpressure, reset and counter wrap.
module tb_demux_2_stream;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_select;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic [15:0]      count0, count1;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [15:0]      m_cnt0 = 16'd0;
  logic [15:0]      m_cnt1 = 16'd0;

  demux_2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_select  (in_select),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .count0     (count0),
    .count1     (count1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two plain queues, pops decided from the pre-edge state.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      m_cnt0 <= 16'd0;
      m_cnt1 <= 16'd0;
    end else begin
      bit acc, p0, p1;
      acc = in_valid && ((in_select ? q1.size() : q0.size()) < DEPTH);
      p0  = out0_ready && (q0.size() > 0);
      p1  = out1_ready && (q1.size() > 0);
      if (p0) begin
        void'(q0.pop_front());
        m_cnt0 <= m_cnt0 + 16'd1;
      end
      if (p1) begin
        void'(q1.pop_front());
        m_cnt1 <= m_cnt1 + 16'd1;
      end
      if (acc) begin
        if (in_select) q1.push_back(in_data);
        else           q0.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'((in_select ? q1.size() : q0.size()) < DEPTH));
    check("out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
    check("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
    check("out0_data", 32'(out0_data), 32'((q0.size() > 0) ? q0[0] : 16'h0000));
    check("out1_data", 32'(out1_data), 32'((q1.size() > 0) ? q1[0] : 16'h0000));
    check("count0", 32'(count0), 32'(m_cnt0));
    check("count1", 32'(count1), 32'(m_cnt1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int pops;
    int guard;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_select  = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    tick();
    check("rst_out0_valid", 32'(out0_valid), 32'd0);
    check("rst_out1_valid", 32'(out1_valid), 32'd0);
    check("rst_count0", 32'(count0), 32'd0);
    check("rst_in_ready_sel0", 32'(in_ready), 32'd1);
    in_select = 1'b1;
    in_valid  = 1'b1;
    #1;
    check("rst_in_ready_sel1", 32'(in_ready), 32'd1);
    tick();
    check("rst_no_push", 32'(out1_valid), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();

    // Basic routing
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    in_valid   = 1'b1;
    in_data    = 16'hAAAA;
    in_select  = 1'b0;
    tick();
    check("route_out0_data", 32'(out0_data), 32'h0000AAAA);
    check("route_out0_valid", 32'(out0_valid), 32'd1);
    in_data   = 16'hBBBB;
    in_select = 1'b1;
    tick();
    check("route_out1_data", 32'(out1_data), 32'h0000BBBB);
    check("route_count0", 32'(count0), 32'd1);
    in_valid = 1'b0;
    tick();
    check("route_count1", 32'(count1), 32'd1);
    check("route_out0_empty", 32'(out0_valid), 32'd0);

    // Full / backpressure
    idle();
    in_valid  = 1'b1;
    in_select = 1'b0;
    in_data   = 16'h1111;
    tick();
    in_data = 16'h2222;
    tick();
    in_data = 16'h9999;
    #1;
    check("full_in_ready_sel0", 32'(in_ready), 32'd0);
    out0_ready = 1'b1;
    #1;
    check("full_pop_no_ready", 32'(in_ready), 32'd0);
    in_select = 1'b1;
    in_valid  = 1'b0;
    #1;
    check("full_in_ready_sel1", 32'(in_ready), 32'd1);
    in_select = 1'b0;
    check("full_head_1111", 32'(out0_data), 32'h00001111);
    tick();
    check("full_head_2222", 32'(out0_data), 32'h00002222);
    check("full_in_ready_back", 32'(in_ready), 32'd1);
    tick();
    check("full_drained", 32'(out0_valid), 32'd0);

    // Simultaneous push and pop on a one-word FIFO0
    idle();
    in_valid = 1'b1;
    in_data  = 16'h5555;
    tick();
    in_data    = 16'h3333;
    out0_ready = 1'b1;
    tick();
    idle();
    check("pp_head_3333", 32'(out0_data), 32'h00003333);
    check("pp_valid", 32'(out0_valid), 32'd1);
    in_valid = 1'b1;
    in_data  = 16'h6666;
    tick();
    in_valid = 1'b0;
    #1;
    check("pp_occ_was_one", 32'(in_ready), 32'd0);

    // Async reset between edges with FIFO0 holding two words
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out0_valid", 32'(out0_valid), 32'd0);
    check("arst_count0", 32'(count0), 32'd0);
    check("arst_out0_data", 32'(out0_data), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h4444;
    tick();
    in_valid = 1'b0;
    check("arst_first_out", 32'(out0_data), 32'h00004444);

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_select  = 1'($urandom_range(0, 1));
      in_data    = 16'($urandom);
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 3) == 0);
      if (i == 1500) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    // Counter wrap on out1 with count0 held at 3
    idle();
    do_reset();
    out0_ready = 1'b1;
    in_valid   = 1'b1;
    in_select  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    out0_ready = 1'b0;
    check("wrap_count0_pre", 32'(count0), 32'd3);
    in_valid   = 1'b1;
    in_select  = 1'b1;
    out1_ready = 1'b1;
    pops  = 0;
    guard = 0;
    while (pops < 65536 && guard < 70000) begin
      if (q1.size() != 0) pops++;
      in_data = 16'($urandom);
      tick();
      guard++;
    end
    idle();
    check("wrap_pop_budget", 32'(pops), 32'd65536);
    check("wrap_count1", 32'(count1), 32'h00000000);
    check("wrap_count0", 32'(count0), 32'd3);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
